// File: rtl/mcpu_pkg.sv
// Shared encodings for the MCPU multicycle controller: states, opcodes and mux selects.
// No logic of its own; pure types and constants.
// Imported by the controller top and its strobe decoder.
package mcpu_pkg;

    // FETCH must stay 0 so the reset value of the debug State port reads as zero
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] ALUB_B     = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Combinational state/opcode -> datapath strobe decode, including the PC write merge.
// Zero latency: outputs follow state, latched opcode, Zero and reset within the cycle.
// No flow control; every strobe is forced low while reset is asserted.
module mcpu_ctrl_decode
    import mcpu_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_rst,
    output logic       o_pc_write_final,
    output logic [1:0] o_pc_source,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op
);

    logic w_pc_write;
    logic w_pc_write_cond;
    logic w_is_bne;

    assign w_is_bne = (i_op == OP_BNE);

    // Moore decode of every strobe; reset overrides the whole table so nothing fires mid-abort
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        o_pc_source     = PCSRC_ALU;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_write     = 1'b0;
        o_reg_dst       = REGDST_RT;
        o_mem_to_reg    = MTR_ALUOUT;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = ALUB_B;
        o_alu_op        = ALUOP_ADD;
        if (!i_rst) begin
            case (i_state)
                S_FETCH: begin
                    o_mem_read  = 1'b1;
                    o_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    o_alu_src_b = ALUB_FOUR;
                end
                S_DECODE: o_alu_src_b = ALUB_IMMSH;
                S_MEMADR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = ALUB_IMM;
                end
                S_MEMRD: begin
                    o_iord     = 1'b1;
                    o_mem_read = 1'b1;
                end
                S_MEMWB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = MTR_MDR;
                end
                S_MEMWR: begin
                    o_iord      = 1'b1;
                    o_mem_write = 1'b1;
                end
                S_RTEXE: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = ALUOP_FUNCT;
                end
                S_RTWB: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = REGDST_RD;
                end
                S_ADDIEX: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = ALUB_IMM;
                end
                S_ADDIWB: o_reg_write = 1'b1;
                S_BRANCH: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_op        = ALUOP_SUB;
                    o_pc_source     = PCSRC_ALUOUT;
                    w_pc_write_cond = 1'b1;
                end
                S_JUMP: begin
                    o_pc_source = PCSRC_JUMP;
                    w_pc_write  = 1'b1;
                    if (i_op == OP_JAL) begin
                        o_reg_write  = 1'b1;
                        o_reg_dst    = REGDST_RA;
                        o_mem_to_reg = MTR_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    // bne inverts the sense of Zero; outside BRANCH the conditional term is masked off
    assign o_pc_write_final = w_pc_write | (w_pc_write_cond & (i_zero ^ w_is_bne));

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle MCPU main control: state register, next-state logic and opcode latch.
// One state per clock; lw 5, sw/R/addi 4, branch/jump 3, illegal 2 cycles.
// No backpressure; async reset abandons the instruction and returns to FETCH.
module mcpu_ctrl
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PC_Write_Final,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] State
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;

    // Next-state: DECODE dispatches on the live opcode, later states on the latched copy
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_RTYPE:      w_next = S_RTEXE;
                    OP_ADDI:       w_next = S_ADDIEX;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J, OP_JAL:  w_next = S_JUMP;
                    default:       w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = S_MEMWB;
            S_RTEXE:  w_next = S_RTWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register and opcode latch; the opcode is captured as DECODE is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= Op;
        end
    end

    assign State = r_state;

    mcpu_ctrl_decode u_decode (
        .i_state          (r_state),
        .i_op             (r_op),
        .i_zero           (Zero),
        .i_rst            (rst),
        .o_pc_write_final (PC_Write_Final),
        .o_pc_source      (PCSource),
        .o_iord           (IorD),
        .o_mem_read       (MemRead),
        .o_mem_write      (MemWrite),
        .o_ir_write       (IRWrite),
        .o_reg_write      (RegWrite),
        .o_reg_dst        (RegDst),
        .o_mem_to_reg     (MemtoReg),
        .o_alu_src_a      (ALUSrcA),
        .o_alu_src_b      (ALUSrcB),
        .o_alu_op         (ALUOp)
    );

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: per-instruction reference model plus literal pins.
// Inputs change 1ns after posedge; outputs are compared at the negedge.
// Opcode is scrambled outside DECODE to show later states rely on the latched copy.
module tb_mcpu_ctrl;

    localparam logic [5:0] T_RT   = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       Zero = 1'b0;
    logic       PC_Write_Final, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB, ALUOp;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    mcpu_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
        .PC_Write_Final(PC_Write_Final), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .State(State)
    );

    always #5 clk = ~clk;

    // Observed outputs as one vector:
    // {pcwf, pcsrc[2], iord, memread, memwrite, irwrite, regwrite, regdst[2], memtoreg[2], asa, asb[2], aluop[2], state[4]}
    logic [21:0] obs;
    assign obs = {PC_Write_Final, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, State};

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {T_RT, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_LW, T_SW};
    endfunction

    // Cycles each instruction class occupies
    function automatic int n_steps(input logic [5:0] op);
        if (op == T_LW) return 5;
        if (op inside {T_SW, T_RT, T_ADDI}) return 4;
        if (op inside {T_BEQ, T_BNE, T_J, T_JAL}) return 3;
        return 2;
    endfunction

    // Expected outputs for step idx of instruction op, straight from the per-instruction description
    function automatic logic [21:0] exp_vec(input logic [5:0] op, input int idx, input logic z);
        logic       pcwf = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, asa = 0;
        logic [1:0] pcsrc = 0, rdst = 0, mtr = 0, asb = 0, aop = 0;
        logic [3:0] st = 0;
        if (idx == 0) begin
            pcwf = 1; mr = 1; irw = 1; asb = 2'b01; st = 0;
        end else if (idx == 1) begin
            asb = 2'b11; st = 1;
        end else if (op == T_LW || op == T_SW) begin
            if (idx == 2) begin asa = 1; asb = 2'b10; st = 2; end
            else if (op == T_SW) begin iord = 1; mw = 1; st = 5; end
            else if (idx == 3) begin iord = 1; mr = 1; st = 3; end
            else begin rw = 1; mtr = 2'b01; st = 4; end
        end else if (op == T_RT) begin
            if (idx == 2) begin asa = 1; aop = 2'b10; st = 6; end
            else begin rw = 1; rdst = 2'b01; st = 7; end
        end else if (op == T_ADDI) begin
            if (idx == 2) begin asa = 1; asb = 2'b10; st = 8; end
            else begin rw = 1; st = 9; end
        end else if (op == T_BEQ || op == T_BNE) begin
            asa = 1; aop = 2'b01; pcsrc = 2'b01; st = 10;
            pcwf = (op == T_BEQ) ? z : !z;
        end else begin
            pcsrc = 2'b10; pcwf = 1; st = 11;
            if (op == T_JAL) begin rw = 1; rdst = 2'b10; mtr = 2'b10; end
        end
        return {pcwf, pcsrc, iord, mr, mw, irw, rw, rdst, mtr, asa, asb, aop, st};
    endfunction

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %06h want %06h (state %0d, t=%0t)", name, got, want, State, $time);
        end
    endtask

    // Runs one instruction from FETCH, entered at posedge+1. zfix>=0 pins Zero in step 2,
    // lit_idx selects a step also compared against a hand-computed literal, and
    // abort_idx pulses reset after that step's compare.
    task automatic run_instr(input logic [5:0] op, input int zfix, input int lit_idx,
                             input logic [21:0] lit_vec, input int abort_idx);
        int n = n_steps(op);
        for (int idx = 0; idx < n; idx++) begin
            Op   = (idx == 1) ? op : 6'($urandom_range(63, 0));
            Zero = (zfix >= 0 && idx == 2) ? zfix[0] : 1'($urandom_range(1, 0));
            @(negedge clk);
            check("model", obs, exp_vec(op, idx, Zero));
            if (idx == lit_idx) check("literal", obs, lit_vec);
            if (idx == abort_idx) begin
                #1 rst = 1'b1;
                #1 check("rst_async", obs, 22'd0);
                @(posedge clk); #1;
                check("rst_held", obs, 22'd0);
                @(negedge clk);
                check("rst_held_neg", obs, 22'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] op;
        // Reset held: everything zero regardless of inputs
        Op = T_LW; Zero = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs, 22'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // lw with FETCH and MEMWB pinned by literals, then a second lw pinning the state trail
        run_instr(T_LW, -1, 0, {1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,4'd0}, -1);
        run_instr(T_LW, -1, 4, {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,4'd4}, -1);
        // Branches with pinned Zero
        run_instr(T_BEQ, 1, 2, {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,4'd10}, -1);
        run_instr(T_BEQ, 0, 2, {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,4'd10}, -1);
        run_instr(T_BNE, 0, 2, {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,4'd10}, -1);
        run_instr(T_BNE, 1, 2, {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,4'd10}, -1);
        // jal, then FETCH must follow
        run_instr(T_JAL, -1, 2, {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,2'b00,4'd11}, -1);
        // Illegal opcode skipped after DECODE
        run_instr(6'b111111, -1, 1, {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,4'd1}, -1);
        run_instr(T_ADDI, -1, 0, {1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,4'd0}, -1);
        // sw aborted by reset while in MEMWR; MemWrite pinned just before
        run_instr(T_SW, -1, 3, {1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,4'd5}, 3);
        run_instr(T_RT, -1, 0, {1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,4'd0}, -1);

        // Randomized instruction stream, roughly one in nine illegal
        for (int k = 0; k < 400; k++) begin
            int sel = $urandom_range(8, 0);
            case (sel)
                0: op = T_RT;   1: op = T_J;   2: op = T_JAL;  3: op = T_BEQ;
                4: op = T_BNE;  5: op = T_ADDI; 6: op = T_LW;  7: op = T_SW;
                default: begin
                    op = 6'($urandom_range(63, 0));
                    while (is_legal(op)) op = 6'($urandom_range(63, 0));
                end
            endcase
            if ($urandom_range(40, 0) == 0)
                run_instr(op, -1, -1, 22'd0, $urandom_range(n_steps(op) - 1, 0));
            else
                run_instr(op, -1, -1, 22'd0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
